// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: elastic byte FIFO between uart_rx and uart_tx, drained one byte per transmitter frame.
// Define UART_FIFO_DROP_OLDEST_EN to overwrite the oldest byte on overflow instead of dropping the new one.
module uart_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                tx_busy,
    output logic                tx_en,
    output logic [7:0]          tx_data,
    output logic [DEPTH_LOG2:0] fifo_count,
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CW     = DEPTH_LOG2 + 1;
    localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  pop, push_acc, ovf_set, overwrite, wr_en;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == COUNT_FULL);

    // A same-cycle pop frees a slot, so a push into a full FIFO is only an overflow without one.
    assign pop      = (state == IDLE) && !fifo_empty && !tx_busy;
    assign push_acc = rx_done && (!fifo_full || pop);
    assign ovf_set  = rx_done && fifo_full && !pop;

`ifdef UART_FIFO_DROP_OLDEST_EN
    assign overwrite = ovf_set;
`else
    assign overwrite = 1'b0;
`endif

    assign wr_en = push_acc || overwrite;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (pop)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt    = WAIT_BUSY;
                wait_cnt_nxt = '0;
            end
            WAIT_BUSY: begin
                // No acknowledge within the window: treat the byte as sent and move on.
                if (tx_busy)
                    state_nxt = WAIT_DONE;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = IDLE;
                else
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tx_en    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            tx_en    <= (state_nxt == LAUNCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            if (pop)
                tx_data <= mem[rd_ptr];
            if (wr_en)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop || overwrite)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (push_acc && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push_acc)
                fifo_count <= fifo_count - CW'(1);
            if (ovf_set)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: directed scenarios plus a randomized phase, checked every cycle
// against a queue-based reference model with a simple responsive transmitter.
module tb_uart_byte_fifo;
    localparam int DEPTH_LOG2 = 4;
    localparam int BUSY_WAIT  = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          rx_data;
    logic                rx_done;
    logic                tx_busy;
    logic                tx_en;
    logic [7:0]          tx_data;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                overflow;
    logic                overflow_clr;

    always #5 clk = ~clk;

    uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_busy      (tx_busy),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: stored bytes as a queue, drain readiness from launch-relative timing.
    logic [7:0] q[$];
    bit         m_ready;
    bit         m_acked;
    int         m_launch;
    bit         exp_tx_en;
    logic [7:0] exp_tx_data;
    bit         exp_ovf;

    logic [7:0] launched_b[$];
    int         launched_c[$];

    // Transmitter model.
    int busy_mode  = 0;
    int start_in   = 0;
    int busy_left  = 0;
    int rise_delay = 1;
    int busy_len   = 1;
    bit rand_tx    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ready     = 1'b1;
        m_acked     = 1'b0;
        m_launch    = 0;
        exp_tx_en   = 1'b0;
        exp_tx_data = 8'h00;
        exp_ovf     = 1'b0;
    endtask

    task automatic model_edge();
        bit pop;
        bit ovf_now;
        pop     = 1'b0;
        ovf_now = 1'b0;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        if (m_ready) begin
            if (q.size() > 0 && tx_busy === 1'b0) begin
                pop      = 1'b1;
                m_ready  = 1'b0;
                m_acked  = 1'b0;
                m_launch = cyc + 1;
            end
        end else if (cyc != m_launch) begin
            if (!m_acked) begin
                if (tx_busy === 1'b1)
                    m_acked = 1'b1;
                else if (cyc - m_launch == BUSY_WAIT)
                    m_ready = 1'b1;
            end else if (tx_busy === 1'b0) begin
                m_ready = 1'b1;
            end
        end
        if (pop)
            exp_tx_data = q.pop_front();
        if (rx_done === 1'b1) begin
            if (q.size() < DEPTH) begin
                q.push_back(rx_data);
            end else begin
                ovf_now = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
                void'(q.pop_front());
                q.push_back(rx_data);
`endif
            end
        end
        exp_tx_en = pop;
        if (ovf_now)
            exp_ovf = 1'b1;
        else if (overflow_clr === 1'b1)
            exp_ovf = 1'b0;
    endtask

    task automatic check_all();
        chk("tx_en",      32'(tx_en),      32'(exp_tx_en));
        chk("tx_data",    32'(tx_data),    32'(exp_tx_data));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
        chk("overflow",   32'(overflow),   32'(exp_ovf));
        if (tx_en === 1'b1) begin
            launched_b.push_back(tx_data);
            launched_c.push_back(cyc);
        end
    endtask

    task automatic tx_model();
        if (busy_mode != 0) begin
            if (start_in > 0) begin
                start_in--;
                if (start_in == 0)
                    busy_left = busy_len;
            end
            if (tx_en === 1'b1) begin
                if (rand_tx) begin
                    rise_delay = int'($urandom_range(1, BUSY_WAIT + 2));
                    busy_len   = int'($urandom_range(1, 6));
                end
                start_in = rise_delay;
            end
            tx_busy = (busy_left > 0);
            if (busy_left > 0)
                busy_left--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
        tx_model();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic set_forced(input logic v);
        busy_mode = 0;
        tx_busy   = v;
    endtask

    task automatic set_resp(input int d, input int len);
        busy_mode  = 1;
        rand_tx    = 1'b0;
        rise_delay = d;
        busy_len   = len;
        start_in   = 0;
        busy_left  = 0;
        tx_busy    = 1'b0;
    endtask

    initial begin
        int base;
        int n0;
        logic [7:0] first;

        rst_n        = 1'b0;
        rx_data      = 8'h00;
        rx_done      = 1'b0;
        tx_busy      = 1'b0;
        overflow_clr = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single byte: launch two cycles after rx_done, exactly once.
        set_resp(1, 20);
        idle(2);
        base = launched_b.size();
        n0   = cyc;
        push(8'hA5);
        idle(30);
        chk("single_launches", 32'(launched_b.size() - base), 32'd1);
        if (launched_b.size() > base) begin
            chk("single_data",    32'(launched_b[base]),      32'h0000_00A5);
            chk("single_latency", 32'(launched_c[base] - n0), 32'd2);
        end

        // Burst ordering while the transmitter is busy.
        set_forced(1'b1);
        base = launched_b.size();
        for (int i = 1; i <= 5; i++)
            push(8'(i));
        chk("burst_count", 32'(fifo_count), 32'd5);
        set_resp(1, 3);
        idle(80);
        chk("burst_launches", 32'(launched_b.size() - base), 32'd5);
        if (launched_b.size() >= base + 5)
            for (int i = 0; i < 5; i++)
                chk("burst_order", 32'(launched_b[base + i]), 32'(i + 1));

        // Overflow: 18 pushes into a 16-deep FIFO.
        set_forced(1'b1);
        base = launched_b.size();
        for (int i = 0; i < 18; i++)
            push(8'(8'h10 + i));
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_flag", 32'(overflow),  32'd1);
        set_resp(1, 2);
        idle(200);
`ifdef UART_FIFO_DROP_OLDEST_EN
        first = 8'h12;
`else
        first = 8'h10;
`endif
        chk("ovf_launches", 32'(launched_b.size() - base), 32'd16);
        if (launched_b.size() >= base + 16)
            for (int i = 0; i < 16; i++)
                chk("ovf_order", 32'(launched_b[base + i]), 32'(first + 8'(i)));
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a push in the pop cycle.
        set_forced(1'b1);
        base = launched_b.size();
        for (int i = 0; i < 16; i++)
            push(8'(8'h40 + i));
        chk("fp_full", 32'(fifo_full), 32'd1);
        set_resp(1, 2);
        push(8'hEE);
        chk("fp_count", 32'(fifo_count), 32'd16);
        chk("fp_ovf",   32'(overflow),   32'd0);
        idle(220);
        chk("fp_launches", 32'(launched_b.size() - base), 32'd17);
        if (launched_b.size() >= base + 17) begin
            chk("fp_first", 32'(launched_b[base]),      32'h0000_0040);
            chk("fp_last",  32'(launched_b[base + 16]), 32'h0000_00EE);
        end

        // Busy never acknowledged: launches spaced by the timeout.
        set_forced(1'b0);
        base = launched_b.size();
        push(8'h71);
        push(8'h72);
        idle(20);
        chk("to_launches", 32'(launched_b.size() - base), 32'd2);
        if (launched_b.size() >= base + 2) begin
            chk("to_spacing", 32'(launched_c[base + 1] - launched_c[base]), 32'(BUSY_WAIT + 2));
            chk("to_data1",   32'(launched_b[base + 1]), 32'h0000_0072);
        end

        // Clear coincident with a new overflow: set wins.
        set_forced(1'b1);
        for (int i = 0; i < 16; i++)
            push(8'(8'h80 + i));
        overflow_clr = 1'b1;
        push(8'h90);
        overflow_clr = 1'b0;
        chk("clr_vs_set", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("clr_alone", 32'(overflow), 32'd0);
        set_resp(1, 2);
        idle(200);

        // Asynchronous reset with bytes buffered and overflow set.
        set_forced(1'b1);
        for (int i = 0; i < 17; i++)
            push(8'(8'hA0 + i));
        chk("rst_pre_count", 32'(fifo_count), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_en",   32'(tx_en),      32'd0);
        chk("rst_tx_data", 32'(tx_data),    32'd0);
        chk("rst_count",   32'(fifo_count), 32'd0);
        chk("rst_empty",   32'(fifo_empty), 32'd1);
        chk("rst_full",    32'(fifo_full),  32'd0);
        chk("rst_ovf",     32'(overflow),   32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        set_forced(1'b0);
        base = launched_b.size();
        idle(10);
        chk("rst_no_launch", 32'(launched_b.size() - base), 32'd0);
        push(8'h5A);
        idle(12);
        chk("rst_next_launches", 32'(launched_b.size() - base), 32'd1);
        if (launched_b.size() > base)
            chk("rst_next_data", 32'(launched_b[base]), 32'h0000_005A);

        // Randomized traffic against a transmitter with random acknowledge delay and frame length.
        set_resp(1, 2);
        rand_tx = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rx_done      = ($urandom_range(0, 2) == 0);
            rx_data      = 8'($urandom);
            overflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        rx_done      = 1'b0;
        overflow_clr = 1'b0;
        idle(400);
        chk("rand_drained", 32'(fifo_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
